concat_frame_packer: RTL and testbench

//   Streaming successor to the fixed 6x5->4x8 concatenation block. Accepts FRAME_N input

---
 rtl/concat_pack_pkg.sv | 22 ++
 rtl/concat_frame_reg.sv | 68 ++++++
 rtl/concat_frame_packer.sv | 121 ++++++++++++
 tb/tb_concat_frame_packer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/concat_pack_pkg.sv
// Shared types and width helpers for the streaming frame packer.
package concat_pack_pkg;

  typedef enum logic [0:0] {StFill, StDrain} state_e;

  function automatic int unsigned calc_total_w(input int unsigned in_w,
                                               input int unsigned frame_n,
                                               input int unsigned pad_w);
    return frame_n * in_w + pad_w;
  endfunction

  function automatic int unsigned calc_nout(input int unsigned total_w,
                                            input int unsigned out_w);
    return total_w / out_w;
  endfunction

  // Counter wide enough to hold 0..limit inclusive.
  function automatic int unsigned calc_cnt_w(input int unsigned limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/concat_frame_reg.sv
// Frame accumulator: writes one field per accept, clears trailing slots and inserts the pad
// when the frame closes.
module concat_frame_reg
  import concat_pack_pkg::*;
#(
  parameter int unsigned IN_W    = 5,
  parameter int unsigned FRAME_N = 6,
  parameter int unsigned PAD_W   = 2,
  parameter logic [((PAD_W > 0) ? PAD_W : 1)-1:0] PAD_VAL = '1,
  parameter int unsigned SLOT_W  = calc_cnt_w(FRAME_N),
  localparam int unsigned TotalW = calc_total_w(IN_W, FRAME_N, PAD_W)
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              wr_en,
  input  logic              close,
  input  logic              clear,
  input  logic [SLOT_W-1:0] slot,
  input  logic [IN_W-1:0]   data,
  output logic [TotalW-1:0] frame
);

  localparam int unsigned FieldW = FRAME_N * IN_W;

  logic [FieldW-1:0] fields_q, fields_d;

  always_comb begin
    fields_d = fields_q;
    if (clear) begin
      fields_d = '0;
    end else if (wr_en) begin
      for (int unsigned k = 0; k < FRAME_N; k++) begin
        if (SLOT_W'(k) == slot) begin
          fields_d[FieldW-1-k*IN_W -: IN_W] = data;
        end else if (close && (SLOT_W'(k) > slot)) begin
          fields_d[FieldW-1-k*IN_W -: IN_W] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      fields_q <= '0;
    end else begin
      fields_q <= fields_d;
    end
  end

  if (PAD_W > 0) begin : g_pad
    logic [PAD_W-1:0] pad_q;

    always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
        pad_q <= '0;
      end else if (clear) begin
        pad_q <= '0;
      end else if (wr_en && close) begin
        pad_q <= PAD_VAL;
      end
    end

    assign frame = {fields_q, pad_q};
  end else begin : g_no_pad
    assign frame = fields_q;
  end

endmodule

// File: rtl/concat_frame_packer.sv
// Collects up to FRAME_N narrow fields into a padded frame, then drains it as OUT_W-bit words.
module concat_frame_packer
  import concat_pack_pkg::*;
#(
  parameter int unsigned IN_W    = 5,
  parameter int unsigned FRAME_N = 6,
  parameter int unsigned PAD_W   = 2,
  parameter logic [((PAD_W > 0) ? PAD_W : 1)-1:0] PAD_VAL = 2'b11,
  parameter int unsigned OUT_W   = 8
) (
  input  logic             clk,
  input  logic             areset,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  output logic             out_short,
  input  logic             out_ready
);

  localparam int unsigned TotalW    = calc_total_w(IN_W, FRAME_N, PAD_W);
  localparam int unsigned Nout      = calc_nout(TotalW, OUT_W);
  localparam int unsigned FieldCntW = calc_cnt_w(FRAME_N);
  localparam int unsigned WordCntW  = calc_cnt_w(Nout);

  localparam logic [FieldCntW-1:0] LastField = FieldCntW'(FRAME_N - 1);
  localparam logic [WordCntW-1:0]  LastWord  = WordCntW'(Nout - 1);

  if ((TotalW % OUT_W) != 0) begin : g_bad_width
    $error("concat_frame_packer: packed frame width is not a multiple of OUT_W");
  end

  state_e                 state_q, state_d;
  logic [FieldCntW-1:0]   field_cnt_q;
  logic [WordCntW-1:0]    word_cnt_q;
  logic                   short_q;
  logic [TotalW-1:0]      frame;

  logic accept, close, xfer, done;

  assign accept = (state_q == StFill) && in_valid;
  assign close  = accept && ((field_cnt_q == LastField) || in_last);
  assign xfer   = (state_q == StDrain) && out_ready;
  assign done   = xfer && (word_cnt_q == LastWord);

  concat_frame_reg #(
    .IN_W    (IN_W),
    .FRAME_N (FRAME_N),
    .PAD_W   (PAD_W),
    .PAD_VAL (PAD_VAL),
    .SLOT_W  (FieldCntW)
  ) u_frame_reg (
    .clk    (clk),
    .areset (areset),
    .wr_en  (accept),
    .close  (close),
    .clear  (done),
    .slot   (field_cnt_q),
    .data   (in_data),
    .frame  (frame)
  );

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= StFill;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill:  if (close) state_d = StDrain;
      StDrain: if (done)  state_d = StFill;
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      field_cnt_q <= '0;
      word_cnt_q  <= '0;
      short_q     <= 1'b0;
    end else if (done) begin
      field_cnt_q <= '0;
      word_cnt_q  <= '0;
      short_q     <= 1'b0;
    end else begin
      if (accept) begin
        field_cnt_q <= field_cnt_q + 1'b1;
      end
      if (close) begin
        short_q <= (field_cnt_q < LastField);
      end
      if (xfer) begin
        word_cnt_q <= word_cnt_q + 1'b1;
      end
    end
  end

  // Word 0 carries the frame MSBs; data is forced to zero outside the drain.
  always_comb begin
    in_ready  = (state_q == StFill);
    out_valid = (state_q == StDrain);
    out_last  = (state_q == StDrain) && (word_cnt_q == LastWord);
    out_short = (state_q == StDrain) && short_q;
    out_data  = '0;
    if (state_q == StDrain) begin
      for (int unsigned i = 0; i < Nout; i++) begin
        if (word_cnt_q == WordCntW'(i)) begin
          out_data = frame[TotalW-1-i*OUT_W -: OUT_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_concat_frame_packer.sv
// Directed bench for concat_frame_packer: default geometry plus a 4x3+4 -> 16 variant.
module tb_concat_frame_packer;

  logic       clk;
  logic       areset;
  logic [4:0] in_data;
  logic       in_valid, in_last, in_ready;
  logic [7:0] out_data;
  logic       out_valid, out_last, out_short, out_ready;

  logic [3:0]  in_data2;
  logic        in_valid2, in_last2, in_ready2;
  logic [15:0] out_data2;
  logic        out_valid2, out_last2, out_short2, out_ready2;

  int n_tests = 0;
  int n_fail  = 0;

  concat_frame_packer dut (
    .clk       (clk),
    .areset    (areset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_short (out_short),
    .out_ready (out_ready)
  );

  concat_frame_packer #(
    .IN_W    (4),
    .FRAME_N (3),
    .PAD_W   (4),
    .PAD_VAL (4'hA),
    .OUT_W   (16)
  ) dut2 (
    .clk       (clk),
    .areset    (areset),
    .in_data   (in_data2),
    .in_valid  (in_valid2),
    .in_last   (in_last2),
    .in_ready  (in_ready2),
    .out_data  (out_data2),
    .out_valid (out_valid2),
    .out_last  (out_last2),
    .out_short (out_short2),
    .out_ready (out_ready2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one field at a negedge; it is accepted at the following posedge.
  task automatic send(input logic [4:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    chk("fill_in_ready", 32'(in_ready), 32'd1);
    chk("fill_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_1to6(input logic last_on_6th);
    for (int k = 1; k <= 5; k++) send(5'(k), 1'b0);
    send(5'd6, last_on_6th);
  endtask

  task automatic chk_word(input logic [7:0] w, input int i, input logic short_exp);
    chk("drain_valid", 32'(out_valid), 32'd1);
    chk("drain_data", 32'(out_data), 32'(w));
    chk("drain_last", 32'(out_last), (i == 3) ? 32'd1 : 32'd0);
    chk("drain_short", 32'(out_short), 32'(short_exp));
    chk("drain_in_ready", 32'(in_ready), 32'd0);
  endtask

  task automatic drain(input logic [31:0] words, input logic short_exp, input bit stall);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] w;
      w = words[31-8*i -: 8];
      if (stall) begin
        out_ready = 1'b0;
        chk_word(w, i, short_exp);
        @(negedge clk);
        chk_word(w, i, short_exp);
      end
      out_ready = 1'b1;
      chk_word(w, i, short_exp);
      @(negedge clk);
    end
    chk("drain_done_valid", 32'(out_valid), 32'd0);
    chk("drain_done_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    clk        = 1'b0;
    areset     = 1'b1;
    in_data    = '0;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    out_ready  = 1'b1;
    in_data2   = '0;
    in_valid2  = 1'b0;
    in_last2   = 1'b0;
    out_ready2 = 1'b0;

    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_short", 32'(out_short), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    areset = 1'b0;

    // Full frame, no backpressure
    send_1to6(1'b0);
    drain(32'h0886_429B, 1'b0, 1'b0);

    // Alternating fields with a stall before every word
    for (int k = 0; k < 6; k++) send((k % 2 == 0) ? 5'h1F : 5'h00, 1'b0);
    drain(32'hF83E_0F83, 1'b0, 1'b1);

    // Short frame closed by in_last on the second field
    send(5'h1F, 1'b0);
    send(5'h1F, 1'b1);
    drain(32'hFFC0_0003, 1'b1, 1'b0);

    // Junk held on the input side during a drain must be ignored
    send_1to6(1'b0);
    in_valid = 1'b1;
    in_data  = 5'h1F;
    in_last  = 1'b1;
    drain(32'h0886_429B, 1'b0, 1'b0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    send(5'd1, 1'b0);
    send(5'd2, 1'b0);
    in_last = 1'b1;
    @(negedge clk);
    in_last = 1'b0;
    chk("lone_last_ignored", 32'(out_valid), 32'd0);
    for (int k = 3; k <= 6; k++) send(5'(k), 1'b0);
    drain(32'h0886_429B, 1'b0, 1'b0);

    // Reset in the middle of a drain discards the frame
    send_1to6(1'b0);
    chk("mid_w0", 32'(out_data), 32'h08);
    @(negedge clk);
    chk("mid_w1", 32'(out_data), 32'h86);
    @(negedge clk);
    chk("mid_w2", 32'(out_data), 32'h42);
    areset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    areset = 1'b0;
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    // in_last on the final field is a normal close
    send_1to6(1'b1);
    drain(32'h0886_429B, 1'b0, 1'b0);

    // Alternate geometry: A,B,C + pad A -> ABCA
    for (int k = 0; k < 3; k++) begin
      in_valid2 = 1'b1;
      in_data2  = 4'(4'hA + k);
      chk("p2_in_ready", 32'(in_ready2), 32'd1);
      @(negedge clk);
    end
    in_valid2 = 1'b0;
    chk("p2_valid", 32'(out_valid2), 32'd1);
    chk("p2_data", 32'(out_data2), 32'hABCA);
    chk("p2_last", 32'(out_last2), 32'd1);
    chk("p2_short", 32'(out_short2), 32'd0);
    out_ready2 = 1'b1;
    @(negedge clk);
    chk("p2_done_valid", 32'(out_valid2), 32'd0);
    chk("p2_done_ready", 32'(in_ready2), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
